// File: rtl/pong_pkg.sv
// pong_pkg: state encoding, score/frame widths and saturating score increment for the pong controller
package pong_pkg;
  localparam int SCORE_W = 4;
  localparam int FRAME_W = 8;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    POINT     = 3'd4,
    GAME_OVER = 3'd5
  } state_t;
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s, input logic [SCORE_W-1:0] lim);
    return (s >= lim) ? s : s + SCORE_W'(1);
  endfunction
endpackage

// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: game-controller bus; master drives frame_tick/start_btn/pause_btn/miss_left/miss_right, slave drives state/ball_reset/ball_enable/paddle_enable/serve_dir/score_left/score_right/game_over/winner
interface pong_game_ctrl_if;
  import pong_pkg::*;
  logic               frame_tick;
  logic               start_btn;
  logic               pause_btn;
  logic               miss_left;
  logic               miss_right;
  logic [2:0]         state;
  logic               ball_reset;
  logic               ball_enable;
  logic               paddle_enable;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic               game_over;
  logic               winner;
  modport master (
    output frame_tick, start_btn, pause_btn, miss_left, miss_right,
    input  state, ball_reset, ball_enable, paddle_enable, serve_dir, score_left, score_right, game_over, winner
  );
  modport slave (
    input  frame_tick, start_btn, pause_btn, miss_left, miss_right,
    output state, ball_reset, ball_enable, paddle_enable, serve_dir, score_left, score_right, game_over, winner
  );
endinterface

// File: rtl/pong_edge_detect.sv
// pong_edge_detect: registered rising-edge pulse; ports clock, reset, d (raw level), pulse (one cycle, one clock after the edge)
module pong_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic pulse
);
  logic prev;
  always_ff @(posedge clock) begin
    if (reset) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= d;
      pulse <= d & ~prev;
    end
  end
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong game FSM (serve/play/pause/point/game-over, scoring); ports clock, reset, bus (pong_game_ctrl_if.slave)
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic             clock,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  state_t             st, st_n;
  logic [FRAME_W-1:0] cnt, cnt_n;
  logic [SCORE_W-1:0] sl, sl_n, sr, sr_n;
  logic               dir, dir_n, win, win_n;
  logic               start_p, pause_p, expire;
  pong_edge_detect u_start (.clock(clock), .reset(reset), .d(bus.start_btn), .pulse(start_p));
  pong_edge_detect u_pause (.clock(clock), .reset(reset), .d(bus.pause_btn), .pulse(pause_p));
  assign expire = bus.frame_tick && cnt <= FRAME_W'(1);
  always_ff @(posedge clock) begin
    if (reset) begin
      st  <= IDLE;
      cnt <= '0;
      sl  <= '0;
      sr  <= '0;
      dir <= 1'b1;
      win <= 1'b0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
      sl  <= sl_n;
      sr  <= sr_n;
      dir <= dir_n;
      win <= win_n;
    end
  end
  always_comb begin
    st_n  = st;
    sl_n  = sl;
    sr_n  = sr;
    dir_n = dir;
    win_n = win;
    cnt_n = (bus.frame_tick && cnt != '0) ? cnt - FRAME_W'(1) : cnt;
    case (st)
      IDLE: if (start_p) begin
        st_n  = SERVE;
        sl_n  = '0;
        sr_n  = '0;
        dir_n = 1'b1;
      end
      SERVE: st_n = expire ? PLAY : SERVE;
      PLAY: if (bus.miss_left) begin
        st_n  = POINT;
        sr_n  = sat_inc(sr, WIN);
        dir_n = 1'b0;
      end else if (bus.miss_right) begin
        st_n  = POINT;
        sl_n  = sat_inc(sl, WIN);
        dir_n = 1'b1;
      end else if (pause_p) st_n = PAUSE;
      PAUSE: st_n = pause_p ? PLAY : PAUSE;
      POINT: if (expire) begin
        st_n  = (sl == WIN || sr == WIN) ? GAME_OVER : SERVE;
        win_n = (sl == WIN || sr == WIN) ? (sr == WIN) : win;
      end
      GAME_OVER: st_n = start_p ? IDLE : GAME_OVER;
      default: st_n = IDLE;
    endcase
    if (st_n != st) cnt_n = (st_n == SERVE) ? FRAME_W'(SERVE_FRAMES) : (st_n == POINT) ? FRAME_W'(POINT_FRAMES) : '0;
  end
  // Decoded outputs follow the state register, so they lag each transition by one clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.ball_reset    <= 1'b1;
      bus.ball_enable   <= 1'b0;
      bus.paddle_enable <= 1'b0;
      bus.game_over     <= 1'b0;
    end else begin
      bus.ball_reset    <= st == IDLE || st == SERVE || st == POINT || st == GAME_OVER;
      bus.ball_enable   <= st == PLAY;
      bus.paddle_enable <= st == SERVE || st == PLAY;
      bus.game_over     <= st == GAME_OVER;
    end
  end
  assign bus.state       = st;
  assign bus.score_left  = sl;
  assign bus.score_right = sr;
  assign bus.serve_dir   = dir;
  assign bus.winner      = win;
endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7, points needed to win (1..15).
REQ-002 Parameter SERVE_FRAMES, default 60, frames the ball is held before launch (1..255).
REQ-003 Parameter POINT_FRAMES, default 30, frames of freeze after a point (1..255).
REQ-004 clock  in  1  system clock; all state changes on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 frame_tick  in  1  one-cycle pulse per video frame.
REQ-007 start_btn  in  1  raw level, 1 = pressed.
REQ-008 pause_btn  in  1  raw level, 1 = pressed.
REQ-009 miss_left  in  1  one-cycle pulse: ball passed the left paddle.
REQ-010 miss_right  in  1  one-cycle pulse: ball passed the right paddle.
REQ-011 state  out  3  current FSM state code.
REQ-012 ball_reset  out  1  registered; holds the ball at the centre while 1.
REQ-013 ball_enable  out  1  registered; ball may move while 1.
REQ-014 paddle_enable  out  1  registered; paddles accept joystick input while 1.
REQ-015 serve_dir  out  1  registered; 0 = launch toward the left, 1 = toward the right.
REQ-016 score_left / score_right  out  4 each  registered player scores.
REQ-017 game_over  out  1  registered; 1 in GAME_OVER only.
REQ-018 winner  out  1  registered; 0 = left, 1 = right; valid while game_over = 1.

Function
REQ-019 The FSM SHALL have the states IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4 and GAME_OVER=5; codes 6-7 SHALL return to IDLE on the next clock.
REQ-020 start_btn and pause_btn SHALL be rising-edge detected with a one-cycle registered delay; "start" and "pause" below mean those edge pulses.
REQ-021 IDLE: on start, the block SHALL clear both scores, set serve_dir to 1 and enter SERVE.
REQ-022 SERVE: a frame counter SHALL load SERVE_FRAMES on entry, decrement on each frame_tick, and enter PLAY on the tick that takes it to 0.
REQ-023 PLAY: on miss_left, score_right SHALL increment, serve_dir SHALL become 0 and the FSM SHALL enter POINT; on miss_right, the mirror SHALL happen (score_left increments, serve_dir becomes 1).
REQ-024 If miss_left and miss_right arrive in the same cycle, miss_left SHALL take priority and miss_right SHALL be discarded.
REQ-025 PLAY: pause SHALL enter PAUSE; pause in PAUSE SHALL return to PLAY with counters and scores unchanged.
REQ-026 Pause SHALL be ignored in every state except PLAY and PAUSE.
REQ-027 A miss in the same cycle as pause SHALL score the point; the pause SHALL be dropped.
REQ-028 POINT: the frame counter SHALL load POINT_FRAMES and count frame_tick to 0.
REQ-029 On POINT expiry, if either score equals WIN_SCORE, the FSM SHALL enter GAME_OVER; otherwise it SHALL enter SERVE.
REQ-030 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-031 GAME_OVER: winner SHALL be set to the side that reached WIN_SCORE; start SHALL enter IDLE, and the next start SHALL begin a new game.
REQ-032 Misses SHALL be ignored outside PLAY.
REQ-033 The output decode SHALL be:
- ball_reset = 1 in IDLE, SERVE, POINT and GAME_OVER.
- ball_enable = 1 in PLAY only.
- paddle_enable = 1 in SERVE and PLAY.
REQ-034 All outputs SHALL change one clock after the state transition that causes them.
REQ-035 The frame counter SHALL be 8 bits and reload on every state entry.

Reset
REQ-036 reset SHALL, with priority over all other inputs, force the following on the next clock:
- state = IDLE, frame counter = 0, edge detector history = 0.
- score_left = score_right = 0, serve_dir = 1, winner = 0.
- ball_reset = 1; ball_enable = paddle_enable = game_over = 0.
REQ-037 reset asserted mid-PLAY or mid-PAUSE SHALL discard the game in progress; no point is scored.

Structure
REQ-038 The shared package pong_pkg SHALL hold the state encoding, score width (4) and frame-counter width (8).
REQ-039 The one sub-module SHALL be pong_edge_detect (registered rising-edge pulse), instantiated once per button.

Verification
REQ-040 Reset, then start, then 60 frame_ticks -> SERVE for exactly 60 ticks, then state = PLAY, ball_enable = 1, ball_reset = 0.
REQ-041 In PLAY, miss_left -> score_right = 1, serve_dir = 0, POINT for 30 ticks, then SERVE.
REQ-042 In PLAY, miss_left and miss_right in the same cycle -> only score_right increments.
REQ-043 In PLAY, pause held for 10 cycles -> a single entry to PAUSE; misses are ignored; a second pause returns to PLAY with scores unchanged.
REQ-044 Right player scores 7 points -> after POINT expiry, game_over = 1, winner = 1; start -> IDLE; start -> scores cleared.
REQ-045 reset asserted in PAUSE with score 3:2 -> next clock IDLE, scores 0:0, ball_reset = 1.
